// File: rtl/prog_loader.sv
// Host-link program loader: parses SYNC/LEN/DATA/CHK frames into 24-bit words
// and writes them at ascending addresses while holding the CPU.
module prog_loader #(
    parameter int            RAM_WORD_WIDTH = 24,
    parameter int            RAM_ADDR_BITS  = 8,
    parameter logic [7:0]    SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [RAM_ADDR_BITS-1:0]  wr_addr,
    output logic [RAM_WORD_WIDTH-1:0] wr_data,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [1:0] {IDLE, LEN, DATA, CHK} state_t;

    state_t                     state;
    logic [7:0]                 words_left;
    logic [RAM_ADDR_BITS-1:0]   addr;
    logic [1:0]                 byte_idx;
    logic [7:0]                 chk;
    logic [15:0]                word_buf;
    logic                       xfer;

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_left <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            chk        <= '0;
            word_buf   <= '0;
        end else begin
            in_ready <= 1'b1;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (xfer) begin
                unique case (state)
                    IDLE: if (in_data == SYNC_BYTE) begin
                        state    <= LEN;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                    end
                    LEN: begin
                        words_left <= in_data;
                        addr       <= '0;
                        byte_idx   <= '0;
                        chk        <= '0;
                        state      <= DATA;
                    end
                    DATA: begin
                        chk <= chk + in_data;
                        if (byte_idx == 2'd2) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= addr;
                            wr_data  <= {word_buf, in_data};
                            addr     <= addr + 1'b1;
                            byte_idx <= '0;
                            // words_left counts remaining words minus one
                            if (words_left == 8'd0) state <= CHK;
                            else words_left <= words_left - 8'd1;
                        end else begin
                            word_buf <= {word_buf[7:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    CHK: begin
                        done     <= (in_data == chk);
                        err      <= (in_data != chk);
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes and frame results are queued
// by the stimulus and popped by a negedge monitor.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        cpu_hold, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wq[$];   // {addr, data}
    logic        rq[$];   // 1 = done expected, 0 = err expected

    prog_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic prev_wr = 1'b0, prev_de = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        logic        r;
        if (!rst) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h", wr_addr, wr_data);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e[31:24]});
                    check("wr_data", {8'd0, wr_data}, {8'd0, e[23:0]});
                end
                check("wr_en_single", {31'd0, prev_wr}, 32'd0);
            end
            if (done || err) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: done %0b err %0b", done, err);
                end else begin
                    r = rq.pop_front();
                    check("done_err", {30'd0, done, err}, {30'd0, r, ~r});
                end
                check("result_single", {31'd0, prev_de}, 32'd0);
            end
            prev_wr <= wr_en;
            prev_de <= done | err;
        end else begin
            prev_wr <= 1'b0;
            prev_de <= 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
        #1;
        check(name, wq.size() + rq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [23:0] w;
        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_outs", {26'd0, wr_en, cpu_hold, busy, done, err, 1'b0}, 0);
        check("rst_addr_data", {wr_addr, wr_data}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_up", {31'd0, in_ready}, 1);

        // 1. Reset mid-DATA after 4 bytes
        send(8'hA5, 0); send(8'h01, 0); send(8'h11, 0); send(8'h22, 0);
        check("t1_hold_before_rst", {30'd0, cpu_hold, busy}, 3);
        rst = 1'b1; #2;
        check("t1_rst_outs", {28'd0, cpu_hold, busy, done, err}, 0);
        check("t1_rst_wr", {31'd0, wr_en}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // 2. Single-word frame
        check("t2_hold_idle", {31'd0, cpu_hold}, 0);
        wq.push_back({8'd0, 24'h010005}); rq.push_back(1'b1);
        send(8'hA5, 0);
        check("t2_hold_sync", {30'd0, cpu_hold, busy}, 3);
        send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
        check("t2_hold_chk", {31'd0, cpu_hold}, 1);
        send(8'h06, 0);
        check("t2_hold_end", {30'd0, cpu_hold, busy}, 0);
        drain("t2_drain");

        // 3. Two words with gaps, good checksum
        wq.push_back({8'd0, 24'h020003}); wq.push_back({8'd1, 24'h0A0000}); rq.push_back(1'b1);
        send(8'hA5, 1); send(8'h01, 2); send(8'h02, 3); send(8'h00, 0);
        send(8'h03, 1); send(8'h0A, 2); send(8'h00, 3); send(8'h00, 0); send(8'h0F, 2);
        drain("t3_drain");

        // 4. Same, bad checksum
        wq.push_back({8'd0, 24'h020003}); wq.push_back({8'd1, 24'h0A0000}); rq.push_back(1'b0);
        send(8'hA5, 0); send(8'h01, 1); send(8'h02, 0); send(8'h00, 3);
        send(8'h03, 0); send(8'h0A, 1); send(8'h00, 0); send(8'h00, 2); send(8'h10, 0);
        check("t4_hold_end", {30'd0, cpu_hold, busy}, 0);
        drain("t4_drain");

        // 5. Junk before SYNC, SYNC value as data; chk = A5+12+34 = EB
        wq.push_back({8'd0, 24'hA51234}); rq.push_back(1'b1);
        send(8'h00, 0); send(8'hFF, 1); send(8'h13, 0);
        check("t5_idle_junk", {31'd0, busy}, 0);
        send(8'hA5, 0); send(8'h00, 0); send(8'hA5, 0); send(8'h12, 0);
        send(8'h34, 0); send(8'hEB, 0);
        drain("t5_drain");

        // 6. 256 words back to back
        s = 8'h00;
        send(8'hA5, 0); send(8'hFF, 0);
        for (int i = 0; i < 256; i++) begin
            w = {i[7:0], ~i[7:0], 8'h5A};
            wq.push_back({i[7:0], w});
            s = s + w[23:16] + w[15:8] + w[7:0];
        end
        rq.push_back(1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = {i[7:0], ~i[7:0], 8'h5A};
            for (int k = 2; k >= 0; k--) begin
                in_data = w[k*8 +: 8];
                @(posedge clk); #1;
            end
        end
        in_data = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
